cache_req_arbiter: RTL and testbench

CACHE_REQ_ARBITER -- requirements
Module: cache_req_arbiter

---
 rtl/cache_req_arbiter_pkg.sv | 38 +++
 rtl/cache_rr_arbiter.sv | 34 +++
 rtl/cache_req_arbiter.sv | 150 +++++++++++++++
 tb/tb_cache_req_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : design_params
// Purpose  : op encodings, request struct and FSM states for cache_req_arbiter
// Revision : 1.0
// ============================================================================
package design_params;

   localparam int OP_W     = 2;
   localparam int REQ_ID_W = 3;
   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 32;

   typedef enum logic [1:0] {
      NO_OP = 2'b00,
      READ  = 2'b01,
      WRITE = 2'b10
   } op_e;

   // Default-width view of one request as it leaves the output register.
   typedef struct packed {
      logic [OP_W-1:0]     op;
      logic [REQ_ID_W-1:0] req_id;
      logic [ADDR_W-1:0]   mem_address;
      logic [DATA_W-1:0]   wdata;
   } arb_req_t;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } arb_state_e;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cache_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_rr_arbiter
// Purpose  : round-robin picker; first set request at or after rr_ptr wins
// Revision : 1.0
// ============================================================================
module cache_rr_arbiter
   import design_params::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = clog2_min1(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant
);

   int idx;

   // Scan from the farthest offset back to rr_ptr so the nearest hit is kept.
   always_comb begin
      grant = '0;
      idx   = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (req[PTR_W'(idx)]) begin
            grant              = '0;
            grant[PTR_W'(idx)] = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/cache_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_req_arbiter
// Purpose  : N:1 cache request arbiter with request-ID tagging and routing.
//            Optional CACHE_REQ_ARB_STATS_EN adds per-requester grant counters.
// Revision : 1.0
// ============================================================================
module cache_req_arbiter
   import design_params::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int OP            = 2,
   parameter int REQ_ID        = 3
)(
   input  logic                                   clk,
   input  logic                                   reset_n,
   input  logic [NUM_REQ-1:0]                     req_valid,
   input  logic [NUM_REQ-1:0][OP-1:0]             req_op,
   input  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_wdata,
   output logic [NUM_REQ-1:0]                     req_ready,
   output logic                                   cache_valid,
   output logic [OP-1:0]                          cache_op,
   output logic [REQ_ID-1:0]                      cache_req_id,
   output logic [ADDRESS_WIDTH-1:0]               cache_addr,
   output logic [DATA_WIDTH-1:0]                  cache_wdata,
   input  logic                                   cache_ready,
   input  logic                                   rsp_valid,
   input  logic [REQ_ID-1:0]                      rsp_req_id,
   input  logic [DATA_WIDTH-1:0]                  rsp_rdata,
   output logic [NUM_REQ-1:0]                     cli_rsp_valid,
   output logic [DATA_WIDTH-1:0]                  cli_rsp_rdata,
`ifdef CACHE_REQ_ARB_STATS_EN
   output logic [NUM_REQ-1:0][15:0]               grant_count,
`endif
   output logic                                   ids_full,
   output logic                                   err_bad_id
);

   localparam int PTR_W   = clog2_min1(NUM_REQ);
   localparam int NUM_IDS = 1 << REQ_ID;

   arb_state_e          state;
   arb_state_e          state_nxt;
   logic [PTR_W-1:0]    rr_ptr;
   logic [NUM_IDS-1:0]  in_use;
   logic [PTR_W-1:0]    owner [NUM_IDS];
   logic                grant_en;
   logic [NUM_REQ-1:0]  grant_vec;
   logic                grant_any;
   logic [PTR_W-1:0]    grant_idx;
   logic [REQ_ID-1:0]   free_id;
   logic                rsp_hit;
   logic [NUM_IDS-1:0]  set_mask;
   logic [NUM_IDS-1:0]  clr_mask;

   assign ids_full = &in_use;
   // The output register may only be reloaded when it is empty or draining.
   assign grant_en = reset_n && !ids_full && ((state == ST_IDLE) || cache_ready);

   cache_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr (
      .req    (req_valid & {NUM_REQ{grant_en}}),
      .rr_ptr (rr_ptr),
      .grant  (grant_vec)
   );

   assign req_ready = grant_vec;
   assign grant_any = |grant_vec;

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_vec[i]) grant_idx = PTR_W'(i);
      end
   end

   // Searched on the registered bitmap, so an ID freed this cycle is not reused.
   always_comb begin
      free_id = '0;
      for (int i = NUM_IDS - 1; i >= 0; i--) begin
         if (!in_use[i]) free_id = REQ_ID'(i);
      end
   end

   assign rsp_hit       = rsp_valid && in_use[rsp_req_id];
   assign cli_rsp_valid = (rsp_hit && reset_n) ? (NUM_REQ'(1) << owner[rsp_req_id]) : '0;
   assign cli_rsp_rdata = rsp_rdata;
   assign set_mask      = grant_any ? (NUM_IDS'(1) << free_id)    : '0;
   assign clr_mask      = rsp_hit   ? (NUM_IDS'(1) << rsp_req_id) : '0;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (grant_any)                 state_nxt = ST_PRESENT;
         ST_PRESENT: if (cache_ready && !grant_any) state_nxt = ST_IDLE;
         default:                                   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   assign cache_valid = (state == ST_PRESENT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cache_op     <= '0;
         cache_req_id <= '0;
         cache_addr   <= '0;
         cache_wdata  <= '0;
         rr_ptr       <= '0;
         in_use       <= '0;
         err_bad_id   <= 1'b0;
         for (int i = 0; i < NUM_IDS; i++) owner[i] <= '0;
      end else begin
         in_use <= (in_use | set_mask) & ~clr_mask;
         if (rsp_valid && !in_use[rsp_req_id]) err_bad_id <= 1'b1;
         if (grant_any) begin
            cache_op       <= req_op[grant_idx];
            cache_addr     <= req_addr[grant_idx];
            cache_wdata    <= req_wdata[grant_idx];
            cache_req_id   <= free_id;
            owner[free_id] <= grant_idx;
            rr_ptr         <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
         end
      end
   end

`ifdef CACHE_REQ_ARB_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grant_count <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_vec[i] && (grant_count[i] != 16'hFFFF))
               grant_count[i] <= grant_count[i] + 16'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_req_arbiter
// Purpose  : scenario bench for cache_req_arbiter with a request scoreboard
// Revision : 1.0
// ============================================================================
module tb_cache_req_arbiter;
   import design_params::*;

   localparam int N   = 4;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int OPW = 2;
   localparam int IDW = 3;

   logic                     clk = 1'b0;
   logic                     reset_n = 1'b0;
   logic [N-1:0]             req_valid;
   logic [N-1:0][OPW-1:0]    req_op;
   logic [N-1:0][AW-1:0]     req_addr;
   logic [N-1:0][DW-1:0]     req_wdata;
   logic [N-1:0]             req_ready;
   logic                     cache_valid;
   logic [OPW-1:0]           cache_op;
   logic [IDW-1:0]           cache_req_id;
   logic [AW-1:0]            cache_addr;
   logic [DW-1:0]            cache_wdata;
   logic                     cache_ready;
   logic                     rsp_valid;
   logic [IDW-1:0]           rsp_req_id;
   logic [DW-1:0]            rsp_rdata;
   logic [N-1:0]             cli_rsp_valid;
   logic [DW-1:0]            cli_rsp_rdata;
   logic                     ids_full;
   logic                     err_bad_id;
`ifdef CACHE_REQ_ARB_STATS_EN
   logic [N-1:0][15:0]       grant_count;
`endif

   typedef struct {
      arb_req_t req;
      int       owner;
      int       due;
   } sb_t;

   sb_t sbq[$];
   int  tests = 0;
   int  fails = 0;

   always #5 clk = ~clk;

   cache_req_arbiter #(
      .NUM_REQ(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .OP(OPW), .REQ_ID(IDW)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready),
      .cache_valid(cache_valid), .cache_op(cache_op), .cache_req_id(cache_req_id),
      .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_ready(cache_ready),
      .rsp_valid(rsp_valid), .rsp_req_id(rsp_req_id), .rsp_rdata(rsp_rdata),
      .cli_rsp_valid(cli_rsp_valid), .cli_rsp_rdata(cli_rsp_rdata),
`ifdef CACHE_REQ_ARB_STATS_EN
      .grant_count(grant_count),
`endif
      .ids_full(ids_full), .err_bad_id(err_bad_id)
   );

   function automatic arb_req_t mk(input int r, input int id);
      arb_req_t e;
      e.op          = 2'(r % 3);
      e.req_id      = 3'(id);
      e.mem_address = 32'h1000_0000 + 32'(r) * 32'h100;
      e.wdata       = 32'hA5A5_0000 + 32'(r);
      return e;
   endfunction

   function automatic arb_req_t observed();
      return {cache_op, cache_req_id, cache_addr, cache_wdata};
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      reset_n = 1'b0;
      req_valid = '0; rsp_valid = 1'b0; cache_ready = 1'b1;
      sbq.delete();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      arb_req_t e;
      for (int r = 0; r < N; r++) begin
         e = mk(r, 0);
         req_op[r] = e.op; req_addr[r] = e.mem_address; req_wdata[r] = e.wdata;
      end
      reset_n = 1'b0; req_valid = '1; cache_ready = 1'b1;
      rsp_valid = 1'b1; rsp_req_id = '0; rsp_rdata = '0;
      repeat (2) @(negedge clk);
      #1;
      tests++;
      if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
      tests++;
      if (cli_rsp_valid !== 4'b0000) begin fails++; $display("FAIL reset_cli_rsp got %b exp 0000", cli_rsp_valid); end
      tests++;
      if ({cache_valid, observed()} !== '0) begin fails++; $display("FAIL reset_cache_out got %b_%h exp 0", cache_valid, observed()); end
      tests++;
      if (ids_full !== 1'b0 || err_bad_id !== 1'b0) begin fails++; $display("FAIL reset_status got full=%b err=%b exp 0 0", ids_full, err_bad_id); end
`ifdef CACHE_REQ_ARB_STATS_EN
      tests++;
      if (grant_count !== '0) begin fails++; $display("FAIL reset_grant_count got %h exp 0", grant_count); end
`endif
      @(negedge clk);
      reset_n = 1'b1; req_valid = '0; rsp_valid = 1'b0;
   endtask

   // All four requesting, cache always ready, every ID answered as it is presented.
   task automatic test_round_robin();
      int  ids[5] = '{0, 1, 0, 1, 0};
      sb_t e;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         req_valid = (c < 5) ? 4'b1111 : 4'b0000;
         cache_ready = 1'b1;
         rsp_valid = 1'b0;
         if (sbq.size() > 0 && sbq[0].due == c) begin
            rsp_valid = 1'b1; rsp_req_id = sbq[0].req.req_id; rsp_rdata = 32'h5000_0000 + 32'(c);
         end
         #1;
         if (sbq.size() > 0 && sbq[0].due == c) begin
            e = sbq.pop_front();
            tests++;
            if (cache_valid !== 1'b1 || observed() !== e.req) begin
               fails++; $display("FAIL rr_cache_out c=%0d got v=%b %h exp %h", c, cache_valid, observed(), e.req);
            end
            tests++;
            if (cli_rsp_valid !== (4'b0001 << e.owner) || cli_rsp_rdata !== 32'h5000_0000 + 32'(c)) begin
               fails++; $display("FAIL rr_rsp_route c=%0d got %b %h exp owner %0d", c, cli_rsp_valid, cli_rsp_rdata, e.owner);
            end
         end
         if (c < 5) begin
            tests++;
            if (req_ready !== 4'(1 << (c % 4))) begin
               fails++; $display("FAIL rr_grant c=%0d got %b exp %b", c, req_ready, 4'(1 << (c % 4)));
            end
            sbq.push_back('{req: mk(c % 4, ids[c]), owner: c % 4, due: c + 1});
         end
      end
      @(negedge clk);
      rsp_valid = 1'b0; req_valid = '0;
      #1;
      tests++;
      if (cache_valid !== 1'b0 || ids_full !== 1'b0) begin
         fails++; $display("FAIL rr_drain got v=%b full=%b exp 0 0", cache_valid, ids_full);
      end
`ifdef CACHE_REQ_ARB_STATS_EN
      tests++;
      if (grant_count !== {16'd1, 16'd1, 16'd1, 16'd2}) begin
         fails++; $display("FAIL rr_grant_count got %h exp 0001000100010002", grant_count);
      end
`endif
   endtask

   // Requester 2 alone; cache stalls the presented request for three cycles.
   task automatic test_hold();
      sb_t e;
      int  accepts = 0;
      req_addr[2] = 32'h0000_1040;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         req_valid = (c <= 3) ? 4'b0100 : 4'b0000;
         cache_ready = (c >= 1 && c <= 3) ? 1'b0 : 1'b1;
         rsp_valid = (c == 5); rsp_req_id = 3'd0; rsp_rdata = 32'h1234_5678;
         #1;
         if (req_ready !== 4'b0000) accepts++;
         if (c == 0) begin
            e.req = mk(2, 0); e.req.mem_address = 32'h0000_1040; e.owner = 2; e.due = 1;
            sbq.push_back(e);
         end
         if (c >= 1 && c <= 4) begin
            e = sbq[0];
            tests++;
            if (cache_valid !== 1'b1 || observed() !== e.req) begin
               fails++; $display("FAIL hold_cache_out c=%0d got v=%b %h exp %h", c, cache_valid, observed(), e.req);
            end
            if (c == 4) void'(sbq.pop_front());
         end
         if (c == 5) begin
            tests++;
            if (cache_valid !== 1'b0 || cli_rsp_valid !== 4'b0100 || cli_rsp_rdata !== 32'h1234_5678) begin
               fails++; $display("FAIL hold_rsp got v=%b cli=%b %h exp 0 0100 12345678", cache_valid, cli_rsp_valid, cli_rsp_rdata);
            end
         end
      end
      tests++;
      if (accepts !== 1) begin fails++; $display("FAIL hold_accepts got %0d exp 1", accepts); end
      req_addr[2] = mk(2, 0).mem_address;
      @(negedge clk);
      rsp_valid = 1'b0;
   endtask

   // Eight unanswered grants exhaust the IDs; freeing ID 5 lets exactly it be reused.
   task automatic test_id_exhaust();
      sb_t e;
      int  r;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         req_valid = (c <= 10) ? 4'b1111 : 4'b0000;
         cache_ready = 1'b1;
         rsp_valid = (c == 9); rsp_req_id = 3'd5; rsp_rdata = 32'hCAFE_0005;
         #1;
         if (sbq.size() > 0 && sbq[0].due == c) begin
            e = sbq.pop_front();
            tests++;
            if (cache_valid !== 1'b1 || observed() !== e.req) begin
               fails++; $display("FAIL full_cache_out c=%0d got v=%b %h exp %h", c, cache_valid, observed(), e.req);
            end
         end else begin
            tests++;
            if (cache_valid !== 1'b0) begin fails++; $display("FAIL full_idle c=%0d got v=%b exp 0", c, cache_valid); end
         end
         if (c < 8) begin
            r = (3 + c) % 4;
            tests++;
            if (req_ready !== 4'(1 << r)) begin fails++; $display("FAIL full_grant c=%0d got %b exp %b", c, req_ready, 4'(1 << r)); end
            sbq.push_back('{req: mk(r, c), owner: r, due: c + 1});
         end else if (c == 8 || c == 9) begin
            tests++;
            if (ids_full !== 1'b1 || req_ready !== 4'b0000) begin
               fails++; $display("FAIL full_block c=%0d got full=%b ready=%b exp 1 0000", c, ids_full, req_ready);
            end
            if (c == 9) begin
               tests++;
               if (cli_rsp_valid !== 4'b0001) begin fails++; $display("FAIL full_free_rsp got %b exp 0001", cli_rsp_valid); end
            end
         end else if (c == 10) begin
            tests++;
            if (ids_full !== 1'b0 || req_ready !== 4'b1000) begin
               fails++; $display("FAIL full_regrant got full=%b ready=%b exp 0 1000", ids_full, req_ready);
            end
            sbq.push_back('{req: mk(3, 5), owner: 3, due: 11});
         end
      end
      apply_reset();
   endtask

   // Requester 1 takes IDs 0..3; the reply on ID 3 must route back to it at once.
   task automatic test_response_route();
      sb_t e;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         req_valid = (c < 4) ? 4'b0010 : 4'b0000;
         cache_ready = 1'b1;
         rsp_valid = (c == 4); rsp_req_id = 3'd3; rsp_rdata = 32'hDEAD_BEEF;
         #1;
         if (sbq.size() > 0 && sbq[0].due == c) begin
            e = sbq.pop_front();
            tests++;
            if (cache_valid !== 1'b1 || observed() !== e.req) begin
               fails++; $display("FAIL route_cache_out c=%0d got v=%b %h exp %h", c, cache_valid, observed(), e.req);
            end
         end
         if (c < 4) sbq.push_back('{req: mk(1, c), owner: 1, due: c + 1});
         if (c == 4) begin
            tests++;
            if (cli_rsp_valid !== 4'b0010 || cli_rsp_rdata !== 32'hDEAD_BEEF) begin
               fails++; $display("FAIL route_rsp got %b %h exp 0010 deadbeef", cli_rsp_valid, cli_rsp_rdata);
            end
         end
      end
   endtask

   task automatic test_bad_id();
      @(negedge clk);
      rsp_valid = 1'b1; rsp_req_id = 3'd6; rsp_rdata = 32'h0BAD_0006;
      #1;
      tests++;
      if (cli_rsp_valid !== 4'b0000 || err_bad_id !== 1'b0) begin
         fails++; $display("FAIL bad_id_drop got cli=%b err=%b exp 0000 0", cli_rsp_valid, err_bad_id);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         rsp_valid = 1'b0;
         #1;
         tests++;
         if (err_bad_id !== 1'b1) begin fails++; $display("FAIL bad_id_sticky c=%0d got %b exp 1", c, err_bad_id); end
      end
   endtask

   // Free ID 0, then stall a new request so the block sits in PRESENT with IDs 0..2 busy.
   task automatic test_reset_inflight();
      @(negedge clk);
      rsp_valid = 1'b1; rsp_req_id = 3'd0; rsp_rdata = 32'h0;
      #1;
      tests++;
      if (cli_rsp_valid !== 4'b0010) begin fails++; $display("FAIL inflight_free got %b exp 0010", cli_rsp_valid); end
      @(negedge clk);
      rsp_valid = 1'b0; req_valid = 4'b0001; cache_ready = 1'b0;
      #1;
      tests++;
      if (req_ready !== 4'b0001) begin fails++; $display("FAIL inflight_grant got %b exp 0001", req_ready); end
      @(negedge clk);
      #1;
      tests++;
      if (cache_valid !== 1'b1 || observed() !== mk(0, 0)) begin
         fails++; $display("FAIL inflight_present got v=%b %h exp 1 %h", cache_valid, observed(), mk(0, 0));
      end
      #2;
      reset_n = 1'b0;
      rsp_valid = 1'b1; rsp_req_id = 3'd1;
      #1;
      tests++;
      if (cache_valid !== 1'b0 || ids_full !== 1'b0 || err_bad_id !== 1'b0 || observed() !== '0) begin
         fails++; $display("FAIL inflight_async_reset got v=%b full=%b err=%b %h exp all 0", cache_valid, ids_full, err_bad_id, observed());
      end
      tests++;
      if (req_ready !== 4'b0000 || cli_rsp_valid !== 4'b0000) begin
         fails++; $display("FAIL inflight_reset_strobes got ready=%b cli=%b exp 0 0", req_ready, cli_rsp_valid);
      end
`ifdef CACHE_REQ_ARB_STATS_EN
      tests++;
      if (grant_count !== '0) begin fails++; $display("FAIL inflight_grant_count got %h exp 0", grant_count); end
`endif
      @(negedge clk);
      reset_n = 1'b1; req_valid = '0;
      #1;
      tests++;
      if (cli_rsp_valid !== 4'b0000 || cache_valid !== 1'b0) begin
         fails++; $display("FAIL inflight_abandoned got cli=%b v=%b exp 0000 0", cli_rsp_valid, cache_valid);
      end
      @(negedge clk);
      rsp_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_hold();
      test_id_exhaust();
      test_response_route();
      test_bad_id();
      test_reset_inflight();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
